// File: rtl/phase_gen.sv
// Phase strobe sequencer: replays SEQ one slot per go edge; strb is registered, so slot 0 appears one edge after start.
// No downstream backpressure; stall freezes the slot pointer and blanks strb, and step is ignored while busy.
module phase_gen #(
    parameter int                          NUM_PH  = 3,
    parameter int                          SEQ_LEN = 4,
    parameter logic [SEQ_LEN*NUM_PH-1:0]   SEQ     = 12'b001_010_100_010,
    parameter int                          CNT_W   = 32,
    localparam int                         PW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              stall,
    output logic [NUM_PH-1:0] strb,
    output logic [PW-1:0]     slot,
    output logic              last,
    output logic              busy,
    output logic [CNT_W-1:0]  insn_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [PW-1:0] LAST_PTR = PW'(SEQ_LEN - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic          go;
    logic          wrap;

    assign go   = !stall && (state != IDLE || run || step);
    assign wrap = (ptr == LAST_PTR);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            strb     <= '0;
            slot     <= '0;
            last     <= 1'b0;
            insn_cnt <= '0;
        end else if (go) begin
            strb <= SEQ[int'(ptr)*NUM_PH +: NUM_PH];
            slot <= ptr;
            last <= wrap;
            if (wrap) begin
                // A single step always ends here; a run sequence restarts only if run is still high.
                ptr      <= '0;
                insn_cnt <= insn_cnt + CNT_W'(1);
                if (state == STEP)
                    state <= IDLE;
                else
                    state <= run ? RUN : IDLE;
            end else begin
                ptr <= ptr + PW'(1);
                if (state == IDLE)
                    state <= run ? RUN : STEP;
            end
        end else begin
            strb <= '0;
            last <= 1'b0;
        end
    end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter NUM_PH, default 3, number of phase strobe outputs (bit0 = PC, bit1 = register file, bit2 = memory).
REQ-002 Parameter SEQ_LEN, default 4, number of slots in one instruction sequence; legal range 1..256.
REQ-003 Parameter SEQ, default 12'b001_010_100_010, packed SEQ_LEN x NUM_PH strobe masks with slot 0 in the LSBs; a mask may be zero or multi-hot.
REQ-004 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-005 Derived width PW = max(1, $clog2(SEQ_LEN)).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 run  input  1  level; free-running sequencing enable.
REQ-009 step  input  1  single-step request, sampled only when idle.
REQ-010 stall  input  1  level; freezes sequencing at the current slot.
REQ-011 strb  output  NUM_PH  registered phase strobes, each high for one clk cycle.
REQ-012 slot  output  PW  registered index of the slot whose mask is on strb.
REQ-013 last  output  1  registered; high together with the strobe of slot SEQ_LEN-1.
REQ-014 busy  output  1  high while state is RUN or STEP.
REQ-015 insn_cnt  output  CNT_W  count of completed sequences.

Function
REQ-016 Internal state SHALL be FSM {IDLE, RUN, STEP}, slot pointer ptr (PW bits), and the output registers.
REQ-017 go SHALL be defined as !stall && (state != IDLE || run || step).
REQ-018 On a go edge: strb <= SEQ[ptr], slot <= ptr, last <= (ptr == SEQ_LEN-1).
REQ-019 On a non-go edge: strb <= 0 and last <= 0; slot, ptr, state and insn_cnt hold.
REQ-020 On a go edge with ptr < SEQ_LEN-1: ptr <= ptr+1; IDLE goes to RUN if run, else to STEP; RUN and STEP hold.
REQ-021 On a go edge with ptr == SEQ_LEN-1 (wrap): ptr <= 0 and insn_cnt <= insn_cnt+1 modulo 2^CNT_W.
REQ-022 On a wrap edge, STEP SHALL go to IDLE; RUN or IDLE SHALL go to RUN if run, else to IDLE.
REQ-023 Start latency SHALL be one edge: run or step sampled high in IDLE puts slot 0's mask on strb after that same edge.
REQ-024 Deasserting run mid-sequence SHALL NOT truncate the sequence; all remaining slots are emitted, then IDLE.
REQ-025 step while busy SHALL be ignored; run and step both high in IDLE SHALL select RUN.
REQ-026 run asserted during STEP SHALL take effect only after the step wraps, giving exactly one idle cycle before slot 0.
REQ-027 stall in IDLE SHALL block start; stall has priority over run and step.
REQ-028 With SEQ_LEN = 1, every go edge SHALL be a wrap.
REQ-029 busy SHALL be decoded from the state register only.

Reset
REQ-030 rst_n low SHALL immediately, without a clock edge, force state = IDLE, ptr = 0, strb = 0, slot = 0, last = 0, insn_cnt = 0 (busy = 0).
REQ-031 Reset mid-sequence SHALL abort the sequence; no remaining slot is emitted after release.
REQ-032 The first go edge after rst_n rises SHALL emit slot 0.

Verification
REQ-033 Defaults, run = 1 held from reset release: strb = 010, 100, 010, 001 repeating from the first edge; last high with 001; insn_cnt = 1 after the 4th strobe and 2 after the 8th.
REQ-034 stall = 1 for 3 cycles after slot 0 is emitted: strb = 0 and slot = 0 for 3 cycles, then 100 with slot = 1 (no skipped slot); insn_cnt is unchanged during the stall.
REQ-035 run dropped right after slot 1: slots 2 and 3 (010, 001) are still emitted, then strb = 0, busy = 0, insn_cnt +1.
REQ-036 One-cycle step pulse in IDLE: exactly 4 strobes, then IDLE; a second step pulse during slot 2 produces no extra strobes.
REQ-037 rst_n dropped asynchronously while strb = 010 (slot 2): all outputs read 0 before the next edge; after release with run = 1, the sequence restarts at slot 0.
REQ-038 NUM_PH = 4, SEQ_LEN = 5, CNT_W = 3, run held: slot cycles 0..4; insn_cnt wraps 7 -> 0 at the 8th completed sequence.
